led_seq_ctrl: RTL and testbench

Programmable LED sequencer and interrupt controller for the PL LED bank. It replaces a free-running LED stream with PS-controlled start/stop, selectable pattern mode and a runtime step period. It raises a sticky level interrupt to the PS at the end of every pattern sweep and holds it until acknowledged. It also counts sweeps that completed while a previous interrupt was still pending.

---
 rtl/led_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// ============================================================================
// Module      : led_seq_ctrl
// Description : LED pattern sequencer with start/stop control and a sticky
//               end-of-sweep interrupt. Define LED_SEQ_CTRL_MISS_CNT_EN to
//               implement the missed-interrupt counter; otherwise it reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_ctrl #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int MISS_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [31:0]       step_period,
  input  logic              intr_ack,
  output logic [3:0]        led,
  output logic              o_intr,
  output logic              busy,
  output logic [MISS_W-1:0] miss_cnt
);

  generate
    if (CLOCK_FREQ < 1 || MISS_W < 1) begin : g_param_check
      $error("led_seq_ctrl: CLOCK_FREQ and MISS_W must be positive");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_period, w_period_nxt;
  logic [1:0]  r_mode, w_mode_nxt;
  logic [2:0]  r_pos, w_pos_nxt;
  logic [3:0]  r_led, w_led_nxt;
  logic        r_intr, w_intr_nxt;
  logic        r_busy, w_busy_nxt;
  logic        w_step;
  logic        w_last;
  logic [2:0]  w_pos_adv;
  logic        w_sweep_end;

  function automatic logic [3:0] pattern(input logic [1:0] m, input logic [2:0] p);
    logic [3:0] v;
    case (m)
      2'd0: v = 4'b0001 << p[1:0];
      2'd1: v = 4'b1000 >> p[1:0];
      2'd2: begin
        case (p)
          3'd0:    v = 4'b0001;
          3'd1:    v = 4'b0010;
          3'd2:    v = 4'b0100;
          3'd3:    v = 4'b1000;
          3'd4:    v = 4'b0100;
          default: v = 4'b0010;
        endcase
      end
      default: v = p[0] ? 4'b0000 : 4'b1111;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] last_pos(input logic [1:0] m);
    logic [2:0] v;
    case (m)
      2'd2:    v = 3'd5;
      2'd3:    v = 3'd1;
      default: v = 3'd3;
    endcase
    return v;
  endfunction

  assign w_step    = (r_cnt == r_period);
  assign w_last    = (r_pos == last_pos(r_mode));
  assign w_pos_adv = w_last ? 3'd0 : r_pos + 3'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_mode_nxt   = r_mode;
    w_pos_nxt    = r_pos;
    w_led_nxt    = r_led;
    w_busy_nxt   = r_busy;
    w_sweep_end  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 32'd0;
        if (start && !stop) begin
          w_state_nxt  = S_RUN;
          w_mode_nxt   = mode;
          w_period_nxt = step_period;
          w_pos_nxt    = 3'd0;
          w_led_nxt    = pattern(mode, 3'd0);
          w_busy_nxt   = 1'b1;
        end
      end
      default: begin
        // stop outranks a step on the same edge, so no interrupt is raised
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 32'd0;
          w_led_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
        end else if (w_step) begin
          w_cnt_nxt   = 32'd0;
          w_pos_nxt   = w_pos_adv;
          w_led_nxt   = pattern(r_mode, w_pos_adv);
          w_sweep_end = w_last;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
    endcase

    w_intr_nxt = r_intr;
    if (w_sweep_end) begin
      w_intr_nxt = 1'b1;
    end else if (intr_ack) begin
      w_intr_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 32'd0;
      r_period <= 32'd0;
      r_mode   <= 2'd0;
      r_pos    <= 3'd0;
      r_led    <= 4'b0000;
      r_intr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_mode   <= w_mode_nxt;
      r_pos    <= w_pos_nxt;
      r_led    <= w_led_nxt;
      r_intr   <= w_intr_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

`ifdef LED_SEQ_CTRL_MISS_CNT_EN
  logic [MISS_W-1:0] r_miss;

  // An ack landing on a sweep end means the PS saw the earlier one: not a miss
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_miss <= '0;
    end else if (w_sweep_end && r_intr && !intr_ack && (r_miss != {MISS_W{1'b1}})) begin
      r_miss <= r_miss + {{(MISS_W-1){1'b0}}, 1'b1};
    end
  end

  assign miss_cnt = r_miss;
`else
  assign miss_cnt = '0;
`endif

  assign led    = r_led;
  assign o_intr = r_intr;
  assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl: directed vector table,
//               scripted corner sequences and randomized traffic vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_seq_ctrl;

  localparam int MISS_W = 8;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [31:0]       step_period;
  logic              intr_ack;
  logic [3:0]        led;
  logic              o_intr;
  logic              busy;
  logic [MISS_W-1:0] miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  led_seq_ctrl #(
    .CLOCK_FREQ(50000000),
    .MISS_W    (MISS_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .step_period(step_period),
    .intr_ack   (intr_ack),
    .led        (led),
    .o_intr     (o_intr),
    .busy       (busy),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed cycles since start, divided into steps and sweeps
  logic [3:0] pat_tab [4][6];
  int         len_tab [4];
  bit         m_run  = 1'b0;
  int         m_mode = 0;
  longint     m_per  = 0;
  longint     m_t    = 0;
  logic [3:0] m_led  = 4'b0000;
  bit         m_intr = 1'b0;
  int         m_miss = 0;

  function automatic logic [3:0] mpat(input int md, input longint step);
    return pat_tab[md][int'(step % longint'(len_tab[md]))];
  endfunction

  function automatic int exp_miss();
`ifdef LED_SEQ_CTRL_MISS_CNT_EN
    return m_miss;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    longint step;
    bit     se;
    if (!rst_n) begin
      m_run = 0; m_led = 4'b0000; m_intr = 0; m_miss = 0; m_t = 0;
    end else if (!m_run) begin
      if (intr_ack) m_intr = 0;
      if (start && !stop) begin
        m_run = 1; m_mode = int'(mode); m_per = longint'(step_period); m_t = 0;
        m_led = mpat(m_mode, 0);
      end
    end else if (stop) begin
      m_run = 0; m_led = 4'b0000;
      if (intr_ack) m_intr = 0;
    end else begin
      m_t++;
      step  = m_t / (m_per + 1);
      se    = ((m_t % (m_per + 1)) == 0) && ((step % longint'(len_tab[m_mode])) == 0);
      m_led = mpat(m_mode, step);
      if (se) begin
        if (m_intr && !intr_ack && m_miss < MISS_MAX) m_miss++;
        m_intr = 1;
      end else if (intr_ack) begin
        m_intr = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("o_intr", 32'(o_intr), 32'(m_intr));
    chk("busy", 32'(busy), 32'(m_run));
    chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss()));
  endtask

  task automatic clear_in();
    start = 1'b0; stop = 1'b0; intr_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input logic [1:0] md, input logic [31:0] per);
    mode = md; step_period = per; start = 1'b1;
    tick();
    clear_in();
  endtask

  typedef struct {
    logic        st;
    logic        sp;
    logic [1:0]  md;
    logic [31:0] per;
    logic        ack;
    logic [3:0]  e_led;
    logic        e_intr;
    logic        e_busy;
  } vec_t;

  vec_t vt [12];

  initial begin
    pat_tab[0] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    pat_tab[1] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
    pat_tab[2] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    pat_tab[3] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    len_tab    = '{4, 4, 6, 2};

    //          st    sp    md    per    ack   led      intr  busy
    vt[0]  = '{1'b1, 1'b0, 2'd3, 32'd1, 1'b0, 4'b1111, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 2'd1, 32'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 2'd3, 32'd1, 1'b0, 4'b1111, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 4'b1111, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 4'b1111, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 4'b1111, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0};

    rst_n = 1'b0; mode = 2'd0; step_period = 32'd0;
    clear_in();

    // Reset and idle
    ticks(2);
    rst_n = 1'b1;
    ticks(10);
    chk("idle_led", 32'(led), 32'h0);
    chk("idle_intr", 32'(o_intr), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_miss", 32'(miss_cnt), 32'h0);

    // Directed vector table: blink, stop, start+stop, ignored start, ack
    for (int i = 0; i < 12; i++) begin
      start = vt[i].st; stop = vt[i].sp; mode = vt[i].md;
      step_period = vt[i].per; intr_ack = vt[i].ack;
      tick();
      clear_in();
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(vt[i].e_led));
      chk($sformatf("vec%0d_intr", i), 32'(o_intr), 32'(vt[i].e_intr));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
    end

    // Shift-left, period 3: four cycles per LED, interrupt on edge 16
    do_start(2'd0, 32'd3);
    chk("sl_first", 32'(led), 32'h1);
    ticks(3);
    chk("sl_hold", 32'(led), 32'h1);
    tick();
    chk("sl_second", 32'(led), 32'h2);
    ticks(11);
    chk("sl_pre_intr", 32'(o_intr), 32'h0);
    chk("sl_last_led", 32'(led), 32'h8);
    tick();
    chk("sl_intr", 32'(o_intr), 32'h1);
    chk("sl_wrap_led", 32'(led), 32'h1);
    ticks(3);
    intr_ack = 1'b1;
    tick();
    clear_in();
    chk("sl_ack", 32'(o_intr), 32'h0);
    stop = 1'b1;
    tick();
    clear_in();

    // Ping-pong, period 0, no ack: second sweep end is a miss
    do_start(2'd2, 32'd0);
    ticks(12);
    chk("pp_intr", 32'(o_intr), 32'h1);
    chk("pp_miss1", 32'(miss_cnt), 32'(exp_miss()));
`ifdef LED_SEQ_CTRL_MISS_CNT_EN
    chk("pp_miss1_abs", 32'(miss_cnt), 32'd1);
`endif
    // Ack coinciding with sweep end: interrupt stays, no miss counted
    ticks(5);
    intr_ack = 1'b1;
    tick();
    clear_in();
    chk("ack_se_intr", 32'(o_intr), 32'h1);
    chk("ack_se_led", 32'(led), 32'h1);
    ticks(24);
`ifdef LED_SEQ_CTRL_MISS_CNT_EN
    chk("pp_miss5_abs", 32'(miss_cnt), 32'd5);
`endif
    // Reset mid-run with an interrupt pending
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_intr", 32'(o_intr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_miss", 32'(miss_cnt), 32'h0);

    // Saturation of the miss counter (blink, period 0)
    do_start(2'd3, 32'd0);
    ticks(520);
`ifdef LED_SEQ_CTRL_MISS_CNT_EN
    chk("miss_sat", 32'(miss_cnt), 32'(MISS_MAX));
`else
    chk("miss_tied", 32'(miss_cnt), 32'h0);
`endif
    intr_ack = 1'b1; stop = 1'b1;
    tick();
    clear_in();
    chk("ack_stop_intr", 32'(o_intr), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom % 8) == 0;
      stop     = ($urandom % 25) == 0;
      intr_ack = ($urandom % 6) == 0;
      mode     = 2'($urandom % 4);
      step_period = (($urandom % 10) == 0) ? 32'hFFFF_FFFF : 32'($urandom % 4);
      rst_n    = ($urandom % 400) != 0;
      tick();
      clear_in();
      rst_n = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
